// File: rtl/pc_unit_if.sv
// Control/address bundle between the control path and the program-counter unit.
// The master drives next-PC controls; the slave (pc_unit) returns the fetch address and RAS status.
interface pc_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              PCWre;
   logic [1:0]        pc_mode;
   logic              branch_taken;
   logic [ADDR_W-1:0] addr_offset;
   logic [ADDR_W-1:0] jump_addr;
   logic [ADDR_W-1:0] reg_target;
   logic              call;
   logic              ret;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_overflow;
   logic              ras_underflow;
   logic              misalign_trap;

   modport master (
      output PCWre, pc_mode, branch_taken, addr_offset, jump_addr, reg_target, call, ret,
      input  pc, pc_plus4, ras_empty, ras_full, ras_overflow, ras_underflow, misalign_trap
   );

   modport slave (
      input  PCWre, pc_mode, branch_taken, addr_offset, jump_addr, reg_target, call, ret,
      output pc, pc_plus4, ras_empty, ras_full, ras_overflow, ras_underflow, misalign_trap
   );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection plus a circular return-address stack with stall.
// Optional target alignment trap enabled by defining PC_ALIGN_CHK_EN.
module pc_unit #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000018c),
   parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h00000180),
   parameter int unsigned       RAS_DEPTH = 4
) (
   input logic       clk,
   input logic       reset,
   pc_unit_if.slave  bus
);
   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
`ifdef PC_ALIGN_CHK_EN
   localparam logic ALIGN_CHK = 1'b1;
`else
   localparam logic ALIGN_CHK = 1'b0;
`endif

   typedef enum logic [1:0] {
      MODE_SEQ    = 2'b00,
      MODE_BRANCH = 2'b01,
      MODE_JUMP   = 2'b10,
      MODE_JREG   = 2'b11
   } pc_mode_e;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              trap_q, trap_d;

   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] target;
   logic [PTR_W-1:0]  top_idx;
   logic [PTR_W-1:0]  ptr_pop;
   logic [CNT_W-1:0]  cnt_pop;
   logic              wr_en;

   // ptr_q is the next free slot; the top of stack sits one below it (mod depth).
   always_comb begin
      pc_plus4 = pc_q + ADDR_W'(4);
      top_idx  = ptr_q - PTR_W'(1);
      target   = pc_plus4;
      ptr_pop  = ptr_q;
      cnt_pop  = cnt_q;
      unf_d    = 1'b0;
      ovf_d    = 1'b0;
      wr_en    = 1'b0;

      unique case (pc_mode_e'(bus.pc_mode))
         MODE_SEQ:    target = pc_plus4;
         MODE_BRANCH: target = bus.branch_taken ? pc_plus4 + (bus.addr_offset << 2) : pc_plus4;
         MODE_JUMP:   target = bus.jump_addr;
         MODE_JREG:   target = bus.reg_target;
         default:     target = pc_plus4;
      endcase

      // Pop first so a simultaneous call overwrites the slot just vacated.
      if (bus.ret) begin
         if (cnt_q != '0) begin
            target  = ras_q[top_idx];
            ptr_pop = top_idx;
            cnt_pop = cnt_q - CNT_W'(1);
         end else begin
            target = bus.reg_target;
            unf_d  = 1'b1;
         end
      end

      ptr_d = ptr_pop;
      cnt_d = cnt_pop;
      if (bus.call) begin
         wr_en = 1'b1;
         ptr_d = ptr_pop + PTR_W'(1);
         if (cnt_pop == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
         else                              cnt_d = cnt_pop + CNT_W'(1);
      end

      trap_d = ALIGN_CHK && (target[1:0] != 2'b00);
      pc_d   = trap_d ? TRAP_VEC : target;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= RESET_VEC;
         ptr_q  <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         trap_q <= 1'b0;
      end else if (bus.PCWre) begin
         pc_q   <= pc_d;
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
         trap_q <= trap_d;
         if (wr_en) ras_q[ptr_pop] <= pc_plus4;
      end else begin
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         trap_q <= 1'b0;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_plus4      = pc_plus4;
   assign bus.ras_empty     = (cnt_q == '0);
   assign bus.ras_full      = (cnt_q == CNT_W'(RAS_DEPTH));
   assign bus.ras_overflow  = ovf_q;
   assign bus.ras_underflow = unf_q;
   assign bus.misalign_trap = trap_q;
endmodule
